// File: rtl/ac97_pkg.sv
// Frame geometry, tag bit positions and receive FSM encoding shared by the
// AC97 record path.
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int TAG_BITS   = 16;
    localparam int SLOT_BITS  = 20;
    localparam int POS_W      = 8;

    localparam logic [POS_W-1:0] SLOT_LEN     = POS_W'(SLOT_BITS);
    localparam logic [POS_W-1:0] LAST_TAG_POS = POS_W'(TAG_BITS - 1);
    localparam logic [POS_W-1:0] LAST_POS     = POS_W'(FRAME_BITS - 1);

    localparam logic [POS_W-1:0] SLOT1_START = 8'd16;
    localparam logic [POS_W-1:0] SLOT2_START = 8'd36;
    localparam logic [POS_W-1:0] SLOT3_START = 8'd56;
    localparam logic [POS_W-1:0] SLOT4_START = 8'd76;
    localparam logic [POS_W-1:0] SLOT3_LAST  = SLOT3_START + SLOT_LEN - 8'd1;
    localparam logic [POS_W-1:0] SLOT4_LAST  = SLOT4_START + SLOT_LEN - 8'd1;

    localparam int TAG_READY_BIT = 15;
    localparam int TAG_SLOT3_BIT = 12;
    localparam int TAG_SLOT4_BIT = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TAG   = 2'd1,
        ST_SLOTS = 2'd2
    } frame_state_e;

    function automatic logic in_slot(input logic [POS_W-1:0] pos,
                                     input logic [POS_W-1:0] start);
        return (pos >= start) && (pos < start + SLOT_LEN);
    endfunction

endpackage

// File: rtl/ac97_slot_shifter.sv
// 20-bit MSB-first deserializer; the load strobe snapshots the word including
// the bit arriving in the same cycle.
module ac97_slot_shifter
    import ac97_pkg::*;
(
    input  logic                 bit_clk,
    input  logic                 rst_b,
    input  logic                 shift_en,
    input  logic                 load,
    input  logic                 sdata,
    output logic [SLOT_BITS-1:0] data
);

    logic [SLOT_BITS-1:0] sr;
    logic [SLOT_BITS-1:0] sr_nxt;

    assign sr_nxt = {sr[SLOT_BITS-2:0], sdata};

    always_ff @(posedge bit_clk or negedge rst_b) begin
        if (!rst_b) begin
            sr   <= '0;
            data <= '0;
        end else begin
            if (shift_en) sr   <= sr_nxt;
            if (load)     data <= sr_nxt;
        end
    end

endmodule

// File: rtl/ac97_record_rx.sv
// AC97 SDATA_IN receiver: frames on SYNC rise, extracts PCM left/right and
// pushes valid pairs to the record FIFO with overflow accounting.
module ac97_record_rx
    import ac97_pkg::*;
#(
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      bit_clk,
    input  logic                      rst_b,
    input  logic                      sync,
    input  logic                      sdata_in,
    input  logic                      rx_enable,
    input  logic                      sample_fifo_full,
    output logic                      sample_fifo_wr_en,
    output logic [2*SLOT_BITS-1:0]    sample_fifo_din,
    output logic                      codec_ready,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    frame_state_e         state, state_nxt;
    logic [POS_W-1:0]     pos;
    logic                 sync_q;
    logic                 sync_rise;
    logic [TAG_BITS-1:0]  tag_sr;
    logic                 capturing;
    logic                 pair_ok;
    logic                 push_pend, drop_pend;
    logic [SLOT_BITS-1:0] left_data, right_data;

    assign sync_rise = sync & ~sync_q;
    assign capturing = (state == ST_SLOTS) && !sync_rise;
    assign pair_ok   = tag_sr[TAG_READY_BIT] & tag_sr[TAG_SLOT3_BIT] &
                       tag_sr[TAG_SLOT4_BIT] & rx_enable;

    always_ff @(posedge bit_clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q <= 1'b0;
            state  <= ST_IDLE;
        end else begin
            sync_q <= sync;
            state  <= state_nxt;
        end
    end

    // A sync rise anywhere abandons the current frame and restarts at bit 0.
    always_comb begin
        state_nxt = state;
        if (sync_rise) begin
            state_nxt = ST_TAG;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_TAG:   if (pos == LAST_TAG_POS) state_nxt = ST_SLOTS;
                ST_SLOTS: if (pos == LAST_POS)     state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge bit_clk or negedge rst_b) begin
        if (!rst_b)
            pos <= '0;
        else if (sync_rise || state == ST_IDLE)
            pos <= '0;
        else
            pos <= pos + 8'd1;
    end

    always_ff @(posedge bit_clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_sr      <= '0;
            codec_ready <= 1'b0;
        end else begin
            if (state == ST_TAG && !sync_rise)
                tag_sr <= {tag_sr[TAG_BITS-2:0], sdata_in};
            if (capturing && pos == POS_W'(TAG_BITS))
                codec_ready <= tag_sr[TAG_READY_BIT];
        end
    end

    ac97_slot_shifter u_left (
        .bit_clk  (bit_clk),
        .rst_b    (rst_b),
        .shift_en (capturing && in_slot(pos, SLOT3_START)),
        .load     (capturing && pos == SLOT3_LAST),
        .sdata    (sdata_in),
        .data     (left_data)
    );

    ac97_slot_shifter u_right (
        .bit_clk  (bit_clk),
        .rst_b    (rst_b),
        .shift_en (capturing && in_slot(pos, SLOT4_START)),
        .load     (capturing && pos == SLOT4_LAST),
        .sdata    (sdata_in),
        .data     (right_data)
    );

    // Push/drop decision is taken with the last right-channel bit, acted on one edge later.
    always_ff @(posedge bit_clk or negedge rst_b) begin
        if (!rst_b) begin
            push_pend <= 1'b0;
            drop_pend <= 1'b0;
        end else begin
            push_pend <= capturing && pos == SLOT4_LAST && pair_ok && !sample_fifo_full;
            drop_pend <= capturing && pos == SLOT4_LAST && pair_ok &&  sample_fifo_full;
        end
    end

    always_ff @(posedge bit_clk or negedge rst_b) begin
        if (!rst_b) begin
            sample_fifo_wr_en <= 1'b0;
            sample_fifo_din   <= '0;
        end else begin
            sample_fifo_wr_en <= push_pend;
            if (push_pend)
                sample_fifo_din <= {left_data, right_data};
        end
    end

    // A drop in the same cycle as a clear wins and counts as the first drop.
    always_ff @(posedge bit_clk or negedge rst_b) begin
        if (!rst_b) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop_pend) begin
            overflow <= 1'b1;
            if (overflow_clr)
                drop_count <= DROP_CNT_WIDTH'(1);
            else if (drop_count != '1)
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
        end else if (overflow_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_ac97_record_rx.sv
// Directed + randomized frame bench for ac97_record_rx with a frame-level
// reference model (expected push queue, overflow flag, saturating drop count).
module tb_ac97_record_rx;

    localparam int DW = 3;

    logic          bit_clk = 1'b0;
    logic          rst_b;
    logic          sync;
    logic          sdata_in;
    logic          rx_enable;
    logic          sample_fifo_full;
    logic          overflow_clr;
    logic          sample_fifo_wr_en;
    logic [39:0]   sample_fifo_din;
    logic          codec_ready;
    logic          overflow;
    logic [DW-1:0] drop_count;

    int checks   = 0;
    int failures = 0;

    int unsigned cyc   = 0;
    int unsigned e_cyc = 0;

    logic [39:0]   obs_q[$];
    int            obs_off[$];
    logic [39:0]   exp_q[$];
    logic          exp_ovf   = 1'b0;
    int            exp_cnt   = 0;
    logic          exp_ready = 1'b0;
    logic [39:0]   exp_din   = '0;

    ac97_record_rx #(.DROP_CNT_WIDTH(DW)) dut (
        .bit_clk           (bit_clk),
        .rst_b             (rst_b),
        .sync              (sync),
        .sdata_in          (sdata_in),
        .rx_enable         (rx_enable),
        .sample_fifo_full  (sample_fifo_full),
        .sample_fifo_wr_en (sample_fifo_wr_en),
        .sample_fifo_din   (sample_fifo_din),
        .codec_ready       (codec_ready),
        .overflow          (overflow),
        .overflow_clr      (overflow_clr),
        .drop_count        (drop_count)
    );

    always #5 bit_clk = ~bit_clk;

    always @(posedge bit_clk) cyc <= cyc + 1;

    always @(negedge bit_clk) begin
        if (sample_fifo_wr_en) begin
            obs_q.push_back(sample_fifo_din);
            obs_off.push_back(int'(cyc - e_cyc));
        end
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drives one frame (or its first nbits bits) starting with a sync rise,
    // then updates the model from the frame's content.
    task automatic send_frame(input logic [15:0] tag, input logic [19:0] l, input logic [19:0] r,
                              input logic full, input logic en, input int nbits, input int clr_p);
        logic [255:0] fr;
        logic valid;
        for (int i = 0; i < 8; i++) fr[i*32 +: 32] = $urandom;
        fr[255:240] = tag;
        fr[199:180] = l;
        fr[179:160] = r;
        sample_fifo_full = full;
        rx_enable        = en;
        sync             = 1'b1;
        @(posedge bit_clk); #1;
        e_cyc = cyc;
        for (int p = 0; p < nbits; p++) begin
            sdata_in     = fr[255-p];
            sync         = (p < 15);
            overflow_clr = (p == clr_p);
            @(posedge bit_clk); #1;
        end
        overflow_clr = 1'b0;
        sync         = 1'b0;

        valid = tag[15] & tag[12] & tag[11] & en;
        if (clr_p >= 0 && clr_p < 96 && clr_p < nbits) begin exp_ovf = 1'b0; exp_cnt = 0; end
        if (nbits > 96 && valid) begin
            if (!full) begin
                exp_q.push_back({l, r});
                exp_din = {l, r};
            end else begin
                exp_ovf = 1'b1;
                if (clr_p == 96)                  exp_cnt = 1;
                else if (exp_cnt < (1 << DW) - 1) exp_cnt = exp_cnt + 1;
            end
        end else if (clr_p == 96 && nbits > 96) begin
            exp_ovf = 1'b0; exp_cnt = 0;
        end
        if (clr_p > 96 && clr_p < nbits) begin exp_ovf = 1'b0; exp_cnt = 0; end
        if (nbits > 16) exp_ready = tag[15];
    endtask

    task automatic check_all(input string name);
        check({name, ":pushes"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({name, ":din"}, 64'(obs_q[i]), 64'(exp_q[i]));
            check({name, ":push_cycle"}, 64'(obs_off[i]), 64'd97);
        end
        check({name, ":din_hold"}, 64'(sample_fifo_din), 64'(exp_din));
        check({name, ":overflow"}, 64'(overflow), 64'(exp_ovf));
        check({name, ":drop_count"}, 64'(drop_count), 64'(exp_cnt));
        check({name, ":codec_ready"}, 64'(codec_ready), 64'(exp_ready));
        obs_q.delete(); obs_off.delete(); exp_q.delete();
    endtask

    initial begin
        logic [19:0] l, r, v20;
        logic [15:0] tag;
        rst_b = 1'b0; sync = 1'b0; sdata_in = 1'b0; rx_enable = 1'b1;
        sample_fifo_full = 1'b0; overflow_clr = 1'b0;
        #23;
        check("reset:wr_en", 64'(sample_fifo_wr_en), 64'd0);
        check("reset:din", 64'(sample_fifo_din), 64'd0);
        check("reset:codec_ready", 64'(codec_ready), 64'd0);
        check("reset:overflow", 64'(overflow), 64'd0);
        check("reset:drop_count", 64'(drop_count), 64'd0);
        @(posedge bit_clk); #1;
        rst_b = 1'b1;
        repeat (3) @(posedge bit_clk);
        #1;

        // Basic valid frame
        send_frame(16'h9800, 20'hFFFCE, 20'h00032, 1'b0, 1'b1, 256, -1);
        check("basic:din_value", 64'(sample_fifo_din), 64'hFF_FCE0_0032);
        check_all("basic");

        // Right slot flagged invalid
        send_frame(16'h9000, 20'h12345, 20'h54321, 1'b0, 1'b1, 256, -1);
        check_all("slot4_invalid");

        // Drop on full FIFO, then clear
        send_frame(16'h9800, 20'h11111, 20'h22222, 1'b1, 1'b1, 256, -1);
        check_all("drop");
        overflow_clr = 1'b1; @(posedge bit_clk); #1; overflow_clr = 1'b0;
        exp_ovf = 1'b0; exp_cnt = 0;
        check_all("clear");

        // Clear coinciding with a drop: the drop wins
        send_frame(16'h9800, 20'h1, 20'h2, 1'b1, 1'b1, 256, -1);
        send_frame(16'h9800, 20'h3, 20'h4, 1'b1, 1'b1, 256, 96);
        check_all("clr_vs_drop");

        // Restart in the middle of slot 2
        send_frame(16'h9800, 20'hAAAAA, 20'hBBBBB, 1'b0, 1'b1, 40, -1);
        send_frame(16'h9800, 20'h00005, 20'h0000C, 1'b0, 1'b1, 256, -1);
        check("restart:left", 64'(sample_fifo_din[39:20]), 64'h00005);
        check_all("restart");

        // Saturation of the drop counter
        for (int i = 0; i < 9; i++)
            send_frame(16'h9800, 20'(i), 20'(i), 1'b1, 1'b1, 256, -1);
        check("saturate:all_ones", 64'(drop_count), 64'((1 << DW) - 1));
        check_all("saturate");

        // Reset during slot 3
        send_frame(16'h9800, 20'h76543, 20'h0F0F0, 1'b0, 1'b1, 60, -1);
        check("pre_reset:codec_ready", 64'(codec_ready), 64'd1);
        rst_b = 1'b0;
        #1;
        check("async_reset:wr_en", 64'(sample_fifo_wr_en), 64'd0);
        check("async_reset:din", 64'(sample_fifo_din), 64'd0);
        check("async_reset:codec_ready", 64'(codec_ready), 64'd0);
        check("async_reset:overflow", 64'(overflow), 64'd0);
        check("async_reset:drop_count", 64'(drop_count), 64'd0);
        exp_ovf = 1'b0; exp_cnt = 0; exp_ready = 1'b0; exp_din = '0;
        obs_q.delete(); obs_off.delete(); exp_q.delete();
        @(posedge bit_clk); #1;
        rst_b = 1'b1;
        for (int i = 0; i < 200; i++) begin
            sdata_in = 1'($urandom);
            @(posedge bit_clk); #1;
        end
        check("post_reset:no_push", 64'(obs_q.size()), 64'd0);
        send_frame(16'h9800, 20'h13579, 20'h2468A, 1'b0, 1'b1, 256, -1);
        check_all("post_reset");

        // Ramp -50..50 on both channels
        for (int v = -50; v <= 50; v++) begin
            v20 = 20'(v);
            send_frame(16'h9800, v20, v20, 1'b0, 1'b1, 256, -1);
        end
        check("ramp:count", 64'(obs_q.size()), 64'd101);
        check("ramp:last", 64'(sample_fifo_din), 64'h00_0320_0032);
        check_all("ramp");

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            int clr_p;
            tag     = 16'($urandom);
            tag[15] = ($urandom_range(3) != 0);
            tag[12] = ($urandom_range(3) != 0);
            tag[11] = ($urandom_range(3) != 0);
            l       = 20'($urandom);
            r       = 20'($urandom);
            case ($urandom_range(5))
                0:       clr_p = 10;
                1:       clr_p = 96;
                2:       clr_p = 150;
                default: clr_p = -1;
            endcase
            send_frame(tag, l, r, ($urandom_range(2) == 0), ($urandom_range(4) != 0), 256, clr_p);
            check_all("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ac97_record_rx.md
AC97_RECORD_RX -- requirements
Module: ac97_record_rx

Interface
REQ-001 Parameter DROP_CNT_WIDTH, default 8, width of the saturating dropped-sample counter.
REQ-002 bit_clk  input  1  sole clock; AC97 bit clock (12.288 MHz); all state updates on rising edge.
REQ-003 rst_b  input  1  reset; asynchronous, active-low.
REQ-004 sync  input  1  AC97 SYNC as driven by the AC97 controller to the codec.
REQ-005 sdata_in  input  1  AC97 SDATA_IN serial stream from the codec.
REQ-006 rx_enable  input  1  when 0, captured frames are never pushed.
REQ-007 sample_fifo_full  input  1  full flag of the record sample FIFO write side.
REQ-008 sample_fifo_wr_en  output  1  single-cycle push strobe to the record FIFO.
REQ-009 sample_fifo_din  output  40  pushed sample pair {left[39:20], right[19:0]}, two's complement PCM.
REQ-010 codec_ready  output  1  tag bit 15 of the most recent completed tag slot.
REQ-011 overflow  output  1  sticky; set when a valid sample pair is dropped because the FIFO is full.
REQ-012 overflow_clr  input  1  synchronous clear of overflow and drop_count.
REQ-013 drop_count  output  DROP_CNT_WIDTH  saturating count of dropped sample pairs.

Function
REQ-014 Sync rising edge SHALL be detected at edge E when sync=1 and registered sync_q=0; sdata_in sampled at edge E+1+p SHALL be frame bit position p (0..255).
REQ-015 Positions 0-15 SHALL form the tag MSB first; 16-35 slot 1; 36-55 slot 2; 56-75 slot 3 (left); 76-95 slot 4 (right); each slot MSB first.
REQ-016 FSM states SHALL be IDLE (await sync rise), TAG (p 0-15), SLOTS (p 16-255); IDLE->TAG on sync rise; TAG->SLOTS after p=15; SLOTS->IDLE after p=255.
REQ-017 A sync rising edge in any state, including mid-frame, SHALL restart framing at p=0 and discard the partial frame without a push.
REQ-018 codec_ready SHALL update at edge E+17 from tag bit 15.
REQ-019 A pair is valid when tag bit 15, bit 12 (slot 3) and bit 11 (slot 4) are all 1 and rx_enable=1 at edge E+96.
REQ-020 For a valid pair with sample_fifo_full=0 at edge E+96: sample_fifo_wr_en SHALL be 1 for exactly the one cycle following edge E+97, with sample_fifo_din stable in that cycle.
REQ-021 For a valid pair with sample_fifo_full=1 at edge E+96: no push; overflow set at edge E+97; drop_count incremented, saturating at all-ones.
REQ-022 sample_fifo_din SHALL hold its last pushed value between pushes; at most one push per frame.
REQ-023 overflow_clr=1 SHALL zero overflow and drop_count on the next edge; a simultaneous drop SHALL take priority (overflow=1, drop_count=1).
REQ-024 Invalid pairs (any required tag bit 0) SHALL produce no push and no overflow change.

Reset
REQ-025 rst_b=0 SHALL immediately force FSM=IDLE, p=0, sync_q=0, sample_fifo_wr_en=0, sample_fifo_din=0, codec_ready=0, overflow=0, drop_count=0.
REQ-026 After rst_b deasserts, no push SHALL occur before a complete frame following a fresh sync rising edge.

Structure
REQ-027 Shared package ac97_pkg SHALL hold frame constants: FRAME_BITS=256, TAG_BITS=16, SLOT_BITS=20, slot start positions, tag bit indices, FSM state encoding.
REQ-028 One sub-module, ac97_slot_shifter (20-bit MSB-first serial-to-parallel with load strobe), is natural and SHALL be used for slots 3 and 4.

Verification
REQ-029 Tag 0x9800, slot3=0xFFFCE, slot4=0x00032, full=0 -> one wr_en pulse in cycle after E+97, din=0xFFFCE00032, codec_ready=1.
REQ-030 Tag 0x9000 (slot 4 invalid) -> no wr_en, overflow stays 0.
REQ-031 Valid frame with full=1 -> no wr_en, overflow=1, drop_count=1; overflow_clr pulse -> both 0.
REQ-032 Sync rise at p=40, then full valid frame with left=0x00005 -> exactly one push, din[39:20]=0x00005.
REQ-033 rst_b low during slot 3 -> all outputs 0 immediately; no push until next full frame after a new sync rise.
REQ-034 101 consecutive valid frames with left=right=-50..50 -> 101 pushes in order, last din=0x0003200032, drop_count=0.
